// File: rtl/r_pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and r_pipe_hazard_ctrl.
// The datapath drives the ID-stage fields and PC; the controller answers with enables and status.
interface r_pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
);
  logic              start;
  logic [PC_W-1:0]   pc;
  // id_valid qualifies id_rs/id_rt/id_rd/id_we/id_uses_rt in the same cycle; the ID slot is
  // consumed only when idex_bubble is low, otherwise it is held (ifid_en low) or replaced.
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_uses_rt;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_bubble;
  logic              stall;
  logic              busy;
  logic              done;

  modport master (
    output start, pc, id_valid, id_rs, id_rt, id_rd, id_we, id_uses_rt,
    input  pc_en, ifid_en, idex_bubble, stall, busy, done
  );

  modport slave (
    input  start, pc, id_valid, id_rs, id_rt, id_rd, id_we, id_uses_rt,
    output pc_en, ifid_en, idex_bubble, stall, busy, done
  );
endinterface

// File: rtl/r_pipe_hazard_ctrl.sv
// RAW hazard scoreboard and start/run/drain/done sequencer for a 5-stage no-forwarding pipeline.
// Optional PERF_CNT_EN adds saturating stall and retire counters.
module r_pipe_hazard_ctrl #(
  parameter int          REG_AW   = 5,
  parameter int          PC_W     = 32,
  parameter int unsigned PC_LIMIT = 124
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r_pipe_hazard_ctrl_if.slave  bus,
  output logic [1:0]           dbg_state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          retire_cnt
`endif
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sb_v_q, sb_v_d;      // index 0 = EX, 1 = MEM, 2 = WB
  logic [REG_AW-1:0] sb_rd_q [3];
  logic [REG_AW-1:0] sb_rd_d [3];
  logic              busy, hazard, match_rs, match_rt, issue, issue_wr, at_limit;

  assign at_limit = bus.pc >= PC_W'(PC_LIMIT);

  // WB still counts as in flight: the register file is written on the same edge ID would leave.
  always_comb begin
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] == bus.id_rs)) match_rs = 1'b1;
      if (sb_v_q[i] && (sb_rd_q[i] == bus.id_rt)) match_rt = 1'b1;
    end
    hazard   = busy && bus.id_valid &&
               ((match_rs && (bus.id_rs != '0)) ||
                (bus.id_uses_rt && match_rt && (bus.id_rt != '0)));
    issue    = busy && bus.id_valid && !hazard;
    issue_wr = issue && bus.id_we && (bus.id_rd != '0);
  end

  always_comb begin
    sb_v_d     = {sb_v_q[1:0], issue_wr};
    sb_rd_d[0] = issue_wr ? bus.id_rd : '0;
    sb_rd_d[1] = sb_rd_q[0];
    sb_rd_d[2] = sb_rd_q[1];
  end

  always_comb begin
    state_d     = state_q;
    bus.pc_en   = 1'b0;
    bus.ifid_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        bus.pc_en   = !hazard;
        bus.ifid_en = !hazard;
        if (at_limit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bus.ifid_en = !hazard;
        if (!bus.id_valid && (sb_v_q == 3'b000)) state_d = S_DONE;
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sb_v_q  <= 3'b000;
      for (int i = 0; i < 3; i++) sb_rd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sb_v_q  <= sb_v_d;
      for (int i = 0; i < 3; i++) sb_rd_q[i] <= sb_rd_d[i];
    end
  end

  assign bus.stall       = hazard;
  assign bus.idex_bubble = !busy || hazard || !bus.id_valid;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == S_DONE);
  assign dbg_state       = state_q;

`ifdef PERF_CNT_EN
  // Non-writing issues never enter the scoreboard, so a parallel shift tracks them to WB.
  logic [2:0]  ret_q, ret_d;
  logic [31:0] stall_cnt_q, stall_cnt_d, retire_cnt_q, retire_cnt_d;

  always_comb begin
    ret_d        = {ret_q[1:0], issue && !issue_wr};
    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if ((state_q == S_IDLE) && bus.start) begin
      stall_cnt_d  = '0;
      retire_cnt_d = '0;
    end else if (state_q != S_DONE) begin
      if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if ((sb_v_q[2] || ret_q[2]) && (retire_cnt_q != '1)) retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q        <= 3'b000;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      ret_q        <= ret_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: doc/r_pipe_hazard_ctrl.md
Name: r_pipe_hazard_ctrl

Overview:
- Sequencing and hazard controller for the 5-stage R-type pipeline CPU: IF, ID, EX, MEM, WB.
- Keeps a scoreboard of destination registers in flight in EX/MEM/WB.
- Stalls PC and the IF/ID register, and inserts bubbles into ID/EX on read-after-write hazards (no-forwarding datapath).
- Runs a start/run/drain/done sequence that stops fetch at the end of instruction memory and reports when the pipeline is empty.

Parameters:
- REG_AW, 5, register address width (32 registers).
- PC_W, 32, PC width.
- PC_LIMIT, 124, PC value at or above which fetch stops (instruction memory bytes minus 4).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution from IDLE.
- pc  in  PC_W  current PC (Output_Addr of the datapath).
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_rd  in  REG_AW  ID destination register.
- id_we  in  1  ID instruction writes id_rd.
- id_uses_rt  in  1  ID instruction reads rt.
- pc_en  out  1  PC may advance this cycle.
- ifid_en  out  1  IF/ID register may load.
- idex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- stall  out  1  hazard stall active.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all scoreboard valids=0.
  - pc_en=0, ifid_en=0, idex_bubble=1, stall=0, busy=0, done=0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: pc>=PC_LIMIT -> DRAIN.
  - DRAIN: id_valid=0 and all scoreboard valids=0 -> DONE.
  - DONE: holds until reset. start is ignored outside IDLE.
- Scoreboard: three entries {v,rd}, one each for EX, MEM and WB. Every cycle: MEM<=EX, WB<=MEM, and EX loads as follows:
  - v=1, rd=id_rd when busy & id_valid & id_we & (id_rd!=0) & ~stall.
  - v=0 otherwise.
- Register file writes at the WB rising edge and reads combinationally. A WB-stage producer therefore still blocks ID in that same cycle, so the hazard window is 3 stages.
- Hazard (combinational), with match(r) = r!=0 and some valid entry has rd==r:
  - hazard = busy & id_valid & (match(id_rs) | (id_uses_rt & match(id_rt))).
  - Register 0 never causes a hazard.
- Outputs:
  - stall = hazard.
  - RUN: pc_en=~hazard, ifid_en=~hazard.
  - DRAIN: pc_en=0, ifid_en=~hazard, and IF delivers no new valid instruction.
  - IDLE and DONE: pc_en=0, ifid_en=0.
  - idex_bubble = ~busy | hazard | ~id_valid.
  - busy and done are decoded from state.
- Stall length: a dependent instruction directly behind its producer stalls 3 cycles. With 1 independent instruction between them it stalls 2 cycles; with 2 between, 1 cycle; with 3 or more, 0 cycles.
- Simultaneous events:
  - RUN->DRAIN takes priority over the stall for pc_en; pc_en is 0 in DRAIN regardless.
  - A hazard during DRAIN still bubbles ID/EX; the scoreboard keeps shifting.
- Reset mid-operation clears the scoreboard and returns to IDLE immediately. No partial drain.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - stall_cnt: increments each cycle stall=1.
  - retire_cnt: increments each cycle the WB entry has v=1, or ID/EX received a non-bubble non-writing instruction 3 cycles earlier (tracked by a parallel 3-deep retire shift bit).
- Both counters are cleared by reset and by start in IDLE, saturate at 0xFFFFFFFF, and freeze in DONE.
- When not defined, neither the ports nor the logic exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no start -> pc_en=0, ifid_en=0, idex_bubble=1, busy=0, done=0 for 10 cycles.
- Back-to-back RAW: ID add $3 with we, then sub $5,$3,$4 with rs=3 -> stall=1 for exactly 3 cycles, pc_en=0 during them, one bubble per stall cycle, then sub issues.
- Spacing: producer rd=7, two independent instructions, then consumer rt=7 with id_uses_rt=1 -> 1 stall cycle. Same pattern with id_uses_rt=0 -> 0 stalls.
- Register zero: producer rd=0, consumer rs=0 -> no stall; the scoreboard EX entry stays v=0.
- End of program: pc steps to 124 -> next cycle busy=1 with pc_en=0 (DRAIN). After id_valid=0 and 3 empty cycles -> done=1, and later start pulses are ignored.
- Async reset mid-stall: assert rst_n=0 between clock edges during a 3-cycle stall -> stall=0 and busy=0 immediately. With PERF_CNT_EN, stall_cnt reads 0 and the next start begins clean.
